// File: rtl/alu_uart_ctrl.sv
// Byte-serial sequencer between the UART RX/TX cores and a combinational ALU:
// gathers A, B and opcode, captures the ALU outputs, then returns the result and status bytes.
module alu_uart_ctrl #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP_CODE = 6,
    parameter int NB_BYTE    = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_BYTE-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_tx_done,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_start,
    output logic [NB_DATA-1:0]    o_data_a,
    output logic [NB_DATA-1:0]    o_data_b,
    output logic [NB_OP_CODE-1:0] o_op_code,
    input  logic [NB_DATA-1:0]    i_alu_result,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_carry,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_timeout
);
    // state    | meaning
    // RX_A     | collecting operand A bytes, LSB first
    // RX_B     | collecting operand B bytes, LSB first
    // RX_OP    | waiting for the opcode byte
    // EXEC     | one cycle: latch ALU result and flags
    // TX_START | pulse o_tx_start with the current result/status byte
    // TX_WAIT  | hold o_tx_data until the TX core reports done

    localparam int NB    = NB_DATA / 8;
    localparam int CNT_W = $clog2(NB + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        RX_A, RX_B, RX_OP, EXEC, TX_START, TX_WAIT
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [TMR_W-1:0]     tmr;
    logic [NB_DATA-1:0]   result;
    logic                 zero;
    logic                 carry;
    logic [NB_BYTE-1:0]   tx_byte;
    logic                 tmr_active;
    logic                 tmr_expire;

    // Index NB selects the status byte; lower indices select result bytes.
    always_comb begin
        tx_byte = {{(NB_BYTE-2){1'b0}}, carry, zero};
        for (int i = 0; i < NB; i++) begin
            if (cnt == CNT_W'(i)) tx_byte = result[i*NB_BYTE +: NB_BYTE];
        end
    end

    // An idle RX_A with no partial operand is never a truncated frame.
    assign tmr_active = (state == RX_B) || (state == RX_OP) ||
                        ((state == RX_A) && (cnt != '0));
    assign tmr_expire = (TIMEOUT != 0) && tmr_active && !i_rx_done &&
                        (tmr == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= RX_A;
            cnt          <= '0;
            tmr          <= '0;
            result       <= '0;
            zero         <= 1'b0;
            carry        <= 1'b0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_data_a     <= '0;
            o_data_b     <= '0;
            o_op_code    <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_tx_start   <= 1'b0;
            o_frame_done <= 1'b0;
            o_timeout    <= 1'b0;

            if (tmr_active && !i_rx_done && !tmr_expire) tmr <= tmr + 1'b1;
            else                                          tmr <= '0;

            if (tmr_expire) begin
                state     <= RX_A;
                cnt       <= '0;
                o_timeout <= 1'b1;
            end else begin
                case (state)
                    RX_A, RX_B: begin
                        if (i_rx_done) begin
                            for (int i = 0; i < NB; i++) begin
                                if (cnt == CNT_W'(i)) begin
                                    if (state == RX_A) o_data_a[i*NB_BYTE +: NB_BYTE] <= i_rx_data;
                                    else               o_data_b[i*NB_BYTE +: NB_BYTE] <= i_rx_data;
                                end
                            end
                            if (cnt == CNT_W'(NB - 1)) begin
                                cnt   <= '0;
                                state <= (state == RX_A) ? RX_B : RX_OP;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    RX_OP: begin
                        if (i_rx_done) begin
                            o_op_code <= i_rx_data[NB_OP_CODE-1:0];
                            o_busy    <= 1'b1;
                            state     <= EXEC;
                        end
                    end
                    EXEC: begin
                        result <= i_alu_result;
                        zero   <= i_alu_zero;
                        carry  <= i_alu_carry;
                        state  <= TX_START;
                    end
                    TX_START: begin
                        o_tx_data  <= tx_byte;
                        o_tx_start <= 1'b1;
                        state      <= TX_WAIT;
                    end
                    TX_WAIT: begin
                        if (i_tx_done) begin
                            if (cnt == CNT_W'(NB)) begin
                                cnt          <= '0;
                                o_frame_done <= 1'b1;
                                o_busy       <= 1'b0;
                                state        <= RX_A;
                            end else begin
                                cnt   <= cnt + 1'b1;
                                state <= TX_START;
                            end
                        end
                    end
                    default: state <= RX_A;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl: stimulus pushes expected TX/frame/timeout events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_alu_uart_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] data_a, data_b;
    logic [5:0] op_code;
    logic [7:0] alu_result;
    logic       alu_zero, alu_carry;
    logic       busy, frame_done, timeout;

    int total = 0;
    int bad = 0;
    int fd_count = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    alu_uart_ctrl #(.NB_DATA(8), .NB_OP_CODE(6), .NB_BYTE(8), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .o_tx_data(tx_data), .o_tx_start(tx_start),
        .o_data_a(data_a), .o_data_b(data_b), .o_op_code(op_code),
        .i_alu_result(alu_result), .i_alu_zero(alu_zero), .i_alu_carry(alu_carry),
        .o_busy(busy), .o_frame_done(frame_done), .o_timeout(timeout)
    );

    // Reference ALU: returns {carry, zero, result}; carry is no-borrow on SUB.
    function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        r = 8'h00;
        c = 1'b0;
        case (op)
            6'h20: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
            6'h22: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = ~w[8]; end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h02: r = a >> b[2:0];
            6'h03: r = $unsigned($signed(a) >>> b[2:0]);
            default: r = 8'h00;
        endcase
        return {c, (r == 8'h00), r};
    endfunction

    always_comb begin
        logic [9:0] f;
        f = alu_ref(data_a, data_b, op_code);
        alu_result = f[7:0];
        alu_zero   = f[8];
        alu_carry  = f[9];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [9:0] act);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected event %0h, expected nothing", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    // Monitor: kind 0 = TX byte, 1 = frame done, 2 = timeout.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                pop_check("tx_byte", {2'd0, tx_data});
                check("busy_in_tx", busy, 1);
            end
            if (frame_done) begin
                pop_check("frame_done", {2'd1, 8'h00});
                fd_count++;
            end
            if (timeout) pop_check("timeout", {2'd2, 8'h00});
        end
    end

    // TX core model: acknowledges each byte after a random delay and checks it was held.
    initial begin
        logic [7:0] cap;
        int lat;
        bit aborted;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !rst) begin
                cap = tx_data;
                lat = $urandom_range(1, 4);
                aborted = 1'b0;
                for (int k = 1; k < lat; k++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                end
                if (!aborted && !rst) begin
                    check("tx_hold", tx_data, cap);
                    tx_done = 1'b1;
                    @(negedge clk);
                    tx_done = 1'b0;
                end
            end
        end
    end

    task automatic push_tx(input logic [7:0] v); exp_q.push_back({2'd0, v}); endtask
    task automatic push_fd();                    exp_q.push_back({2'd1, 8'h00}); endtask
    task automatic push_to();                    exp_q.push_back({2'd2, 8'h00}); endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        logic [9:0] f;
        f = alu_ref(a, b, op[5:0]);
        push_tx(f[7:0]);
        push_tx({6'b0, f[9], f[8]});
        push_fd();
        send_byte(a, $urandom_range(0, 3));
        send_byte(b, $urandom_range(0, 3));
        send_byte(op, $urandom_range(0, 3));
    endtask

    task automatic wait_fd(input string name);
        int start;
        bit got;
        start = fd_count;
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (fd_count != start) got = 1'b1;
        end
        @(negedge clk);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s: frame_done not seen, expected within 300 cycles", name);
        end
    endtask

    task automatic wait_tx_start(input string name, output int cycles);
        cycles = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (tx_start) begin cycles = k; break; end
        end
        total++;
        if (cycles == 0) begin
            bad++;
            $display("FAIL %s: tx_start not seen, expected within 50 cycles", name);
        end
    endtask

    initial begin
        int k;
        logic [7:0] ops[8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
        logic [7:0] a, b, op;

        rst = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {tx_data, tx_start, data_a, data_b, op_code, busy, frame_done, timeout}, 0);
        rst = 1'b0;

        // ADD 5+3, with EXEC exactly one cycle after the opcode
        push_tx(8'h08); push_tx(8'h00); push_fd();
        send_byte(8'h05, 0); send_byte(8'h03, 0); send_byte(8'h20, 0);
        wait_tx_start("add_tx_start", k);
        check("exec_latency", k, 2);
        wait_fd("add");
        check("add_a", data_a, 8'h05);
        check("add_b", data_b, 8'h03);
        check("add_op", op_code, 6'h20);
        check("busy_idle", busy, 0);

        // SUB flags
        push_tx(8'h00); push_tx(8'h03); push_fd();
        send_byte(8'h05, 1); send_byte(8'h05, 2); send_byte(8'h22, 0);
        wait_fd("sub_equal");
        push_tx(8'hFE); push_tx(8'h00); push_fd();
        send_byte(8'h03, 0); send_byte(8'h05, 0); send_byte(8'h22, 3);
        wait_fd("sub_borrow");

        // ADD overflow; opcode upper bits ignored
        push_tx(8'h00); push_tx(8'h03); push_fd();
        send_byte(8'hFF, 0); send_byte(8'h01, 0); send_byte(8'h20, 0);
        wait_fd("add_carry");
        push_tx(8'h03); push_tx(8'h00); push_fd();
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'hE0, 0);
        wait_fd("op_mask");
        check("op_mask_code", op_code, 6'h20);

        // Truncated frame times out after 16 idle cycles
        push_to();
        send_byte(8'h05, 0); send_byte(8'h03, 0);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (timeout) begin k = i; break; end
        end
        check("timeout_latency", k, 16);
        check("timeout_keeps_b", data_b, 8'h03);
        repeat (40) @(negedge clk);
        push_tx(8'h02); push_tx(8'h00); push_fd();
        send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h20, 0);
        wait_fd("after_timeout");
        check("after_timeout_a", data_a, 8'h01);

        // A byte arriving on the expiry cycle is accepted instead of timing out
        push_tx(8'h08); push_tx(8'h00); push_fd();
        send_byte(8'h05, 0); send_byte(8'h03, 14); send_byte(8'h20, 14);
        wait_fd("expiry_edge");

        // Byte injected during TX_WAIT is dropped
        push_tx(8'h30); push_tx(8'h00); push_fd();
        send_byte(8'h10, 0); send_byte(8'h20, 0); send_byte(8'h20, 0);
        wait_tx_start("drop_tx_start", k);
        rx_data = 8'hAA;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        wait_fd("drop");
        check("drop_a", data_a, 8'h10);
        push_tx(8'h07); push_tx(8'h00); push_fd();
        send_byte(8'h07, 0); send_byte(8'h03, 0); send_byte(8'h25, 0);
        wait_fd("after_drop");

        // Reset in the middle of transmitting the result byte
        push_tx(8'h08);
        send_byte(8'h05, 0); send_byte(8'h03, 0); send_byte(8'h20, 0);
        wait_tx_start("rst_tx_start", k);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check("mid_tx_reset", {tx_data, tx_start, data_a, data_b, op_code, busy, frame_done, timeout}, 0);
        rst = 1'b0;
        push_tx(8'h0C); push_tx(8'h00); push_fd();
        send_byte(8'h04, 0); send_byte(8'h08, 0); send_byte(8'h25, 0);
        wait_fd("after_reset");

        // Random frames against the reference ALU
        for (int n = 0; n < 24; n++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = ops[$urandom_range(0, 7)] | {2'($urandom), 6'h00};
            send_frame(a, b, op);
            wait_fd("random_frame");
            check("random_a", data_a, a);
            check("random_b", data_b, b);
            check("random_op", op_code, op[5:0]);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
Sequencer between the UART byte interface (RX/TX cores) and the combinational ALU.
- Collects a frame from the RX stream: operand A, operand B, opcode.
- Drives the ALU from registered operands and captures result, zero and carry.
- Streams the result bytes followed by a status byte back through the TX core.
- Recovers from truncated frames with an inter-byte timeout.

Parameters:
NB_DATA, 8, ALU data width; must be a multiple of 8; operands and result move LSB byte first.
NB_OP_CODE, 6, ALU opcode width; taken from the low bits of the opcode byte, upper bits ignored.
NB_BYTE, 8, UART byte width.
TIMEOUT, 50000, clocks allowed between bytes of a partial frame; 0 disables the timeout.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_rx_data  in  NB_BYTE  received byte; valid while i_rx_done=1
i_rx_done  in  1  one-cycle pulse, new RX byte
i_tx_done  in  1  one-cycle pulse, TX core finished a byte
o_tx_data  out  NB_BYTE  byte to transmit; stable from o_tx_start until i_tx_done
o_tx_start  out  1  one-cycle pulse, start TX of o_tx_data
o_data_a  out  NB_DATA  registered operand A to ALU
o_data_b  out  NB_DATA  registered operand B to ALU
o_op_code  out  NB_OP_CODE  registered opcode to ALU
i_alu_result  in  NB_DATA  ALU result
i_alu_zero  in  1  ALU zero flag
i_alu_carry  in  1  ALU carry flag (borrow-inverted on SUB)
o_busy  out  1  high in EXEC/TX states
o_frame_done  out  1  one-cycle pulse after the status byte's i_tx_done
o_timeout  out  1  one-cycle pulse when a partial frame is aborted

Behaviour:
Interface:
- One clock i_clk.
- i_rst is synchronous, active-high, and has priority over all other events at any state, including mid-RX and mid-TX.

Reset values:
- All outputs are 0.
- State is RX_A; byte counter and timeout counter are 0; result and flag registers are 0.

States:
- RX_A, RX_B, RX_OP: receive phases.
- EXEC: capture ALU outputs.
- TX_START, TX_WAIT: transmit phases.

Receive (NB = NB_DATA/8):
- In RX_A and RX_B, each i_rx_done writes i_rx_data into byte[cnt] of the operand register, then cnt++.
- After byte NB-1: cnt=0 and the state advances to the next phase.
- RX_OP: one i_rx_done loads o_op_code <= i_rx_data[NB_OP_CODE-1:0], then the state goes to EXEC.
- Operand and opcode outputs change only on these writes and otherwise hold their values.

Execute:
- EXEC lasts exactly 1 cycle and latches i_alu_result, i_alu_zero and i_alu_carry.
- Timing: opcode byte i_rx_done at cycle t -> EXEC at t+1 -> TX_START at t+2.

Transmit:
- TX_START asserts o_tx_start for 1 cycle, with o_tx_data = result byte[cnt] for cnt < NB, or status byte {6'b0, carry, zero} for cnt = NB.
- The state then goes to TX_WAIT.
- TX_WAIT holds o_tx_data until i_tx_done, then cnt++.
  - If the status byte is done: pulse o_frame_done, cnt=0, state RX_A.
  - Otherwise: state TX_START.
- i_tx_done outside TX_WAIT is ignored.

Dropped bytes:
- i_rx_done in EXEC, TX_START or TX_WAIT is ignored; the byte is dropped and does not prefill the next frame.

Timeout:
- The counter is active when in RX_B or RX_OP, or in RX_A with cnt > 0.
- It clears on every accepted byte and increments otherwise.
- When it reaches TIMEOUT:
  - o_timeout pulses.
  - State goes to RX_A with cnt=0.
  - Operand and opcode registers keep their old values.
- An i_rx_done in the same cycle as expiry wins: the byte is accepted and there is no timeout.
- Idle RX_A with cnt=0 never times out.

Width rules:
- The status byte is always NB_BYTE wide.
- The TX byte index is log2(NB+1) bits wide.

Test Plan:
1. Frame 0x05,0x03,0x20 (ADD) -> o_data_a=05, o_data_b=03, o_op_code=20; EXEC 1 cycle after opcode; TX 0x08 then 0x00; o_frame_done one pulse.
2. Frame 0x05,0x05,0x22 (SUB) -> TX 0x00 then 0x03 (carry=1, zero=1). Frame 0x03,0x05,0x22 -> TX 0xFE then 0x00.
3. Frame 0xFF,0x01,0x20 -> TX 0x00 then 0x03. Opcode byte 0xE0 -> o_op_code=6'h20.
4. With TIMEOUT=16: send 0x05,0x03 then idle 16 cycles -> o_timeout pulse, state RX_A. Next frame 0x01,0x01,0x20 -> TX 0x02,0x00.
5. Inject i_rx_done=0xAA while in TX_WAIT -> byte ignored, o_tx_data unchanged; next frame decodes correctly.
6. Assert i_rst during TX_WAIT of the result byte -> next cycle all outputs 0, state RX_A; a subsequent full frame returns correct bytes.
